// File: rtl/vga_line_fetch.sv
// -----------------------------------------------------------------------------
// vga_line_fetch
// Ping-pong line buffer between an 8-bit grayscale image memory and a VGA
// display controller. One buffer is shown on screen (each source pixel
// doubled horizontally, each source line shown on two display rows) while the
// other is filled from memory by a one-read-at-a-time fetch engine.
// -----------------------------------------------------------------------------
module vga_line_fetch #(
   parameter int SRC_W = 320,
   parameter int SRC_H = 240
) (
   input  logic        clk27,
   input  logic        rst27,
   input  logic [9:0]  current_x,
   input  logic [9:0]  current_y,
   input  logic        request,
   input  logic        vga_vs,
   output logic        mem_rd,
   output logic [16:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic [9:0]  r,
   output logic [9:0]  g,
   output logic [9:0]  b,
   output logic        busy,
   output logic        underrun
);

   localparam int COL_W = $clog2(SRC_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [16:0]        addr_q, addr_d;
   logic [7:0]         data_q;

   logic               vs_q;          // previous vga_vs, for falling-edge detect
   logic               req_q;         // previous request, for rising-edge detect
   logic               disp_q;        // index of the buffer being displayed
   logic               underrun_q;
   logic               frame_init_q;  // next swap is the first of the frame
   logic               row0_done_q;   // row 0 of this frame has been fetched
   logic               synced_q;      // a frame sync has been seen since reset

   logic [7:0]         pix_q;

   logic               fsync;
   logic               req_rise;
   logic               swap_evt;
   logic               fetching;
   logic               last_col;
   logic               buf_we;
   logic               fetch_done;
   logic               fill_sel;
   logic               rd_sel;
   logic [9:0]         next_row;
   logic [16:0]        next_row_base;
   logic [9:0]         x_src;
   logic               x_in_range;

   logic [7:0]         line_buf [2][SRC_W];

   // ---------------------------------------------------------------------------
   // Event decode
   // ---------------------------------------------------------------------------
   // A new frame starts on the falling edge of the active-low vertical sync.
   assign fsync    = vs_q & ~vga_vs;
   assign req_rise = request & ~req_q;

   // Only even display rows start a new source line; odd rows repeat it.
   // Swaps are ignored until the first frame sync after reset, and lose to a
   // simultaneous frame sync.
   assign swap_evt = synced_q & req_rise & ~current_y[0] & ~fsync;

   // Source row needed after this swap; the display row pair just starting
   // shows row (y>>1), so the fill buffer must receive the one after it.
   assign next_row      = (current_y >> 1) + 10'd1;
   assign next_row_base = 17'(next_row) * 17'(SRC_W);

   assign fetching   = (state_q != S_IDLE);
   assign last_col   = (col_q == COL_W'(SRC_W - 1));
   assign fill_sel   = ~disp_q;

   // A write that coincides with an abort belongs to a line being discarded.
   assign buf_we     = (state_q == S_WRITE) & ~fsync & ~swap_evt;
   assign fetch_done = buf_we & last_col;

   // ---------------------------------------------------------------------------
   // Fetch FSM
   // ---------------------------------------------------------------------------
   // State register together with the column counter and read address.
   always_ff @(posedge clk27 or posedge rst27) begin
      if (rst27) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         addr_q  <= '0;
      end else begin
         // NOTE: sequential state always uses non-blocking assignments so every
         // register samples the pre-edge values regardless of block ordering.
         state_q <= state_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state logic: frame sync beats swap, swap beats the normal walk.
   always_comb begin
      // NOTE: every signal gets a default before the branches so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      col_d   = col_q;
      addr_d  = addr_q;

      if (fsync) begin
         state_d = S_REQ;
         col_d   = '0;
         addr_d  = '0;
      end else if (swap_evt) begin
         col_d = '0;
         if (next_row < 10'(SRC_H)) begin
            state_d = S_REQ;
            addr_d  = next_row_base;
         end else begin
            state_d = S_IDLE;
         end
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_REQ: begin
               if (mem_ack) begin
                  state_d = S_WRITE;
               end
            end
            S_WRITE: begin
               if (last_col) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_REQ;
                  col_d   = col_q + COL_W'(1);
                  addr_d  = addr_q + 17'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs decoded from the current state only, so reset drops them at once.
   always_comb begin
      mem_rd   = (state_q == S_REQ);
      busy     = fetching;
      mem_addr = addr_q;
      r        = {pix_q, pix_q[7:6]};
      g        = {pix_q, pix_q[7:6]};
      b        = {pix_q, pix_q[7:6]};
      underrun = underrun_q;
   end

   // ---------------------------------------------------------------------------
   // Frame / line control
   // ---------------------------------------------------------------------------
   // Edge detectors, buffer ownership and the sticky underrun flag.
   always_ff @(posedge clk27 or posedge rst27) begin
      if (rst27) begin
         vs_q         <= 1'b1;
         req_q        <= 1'b0;
         disp_q       <= 1'b0;
         underrun_q   <= 1'b0;
         frame_init_q <= 1'b0;
         row0_done_q  <= 1'b0;
         synced_q     <= 1'b0;
      end else begin
         vs_q  <= vga_vs;
         req_q <= request;

         if (fsync) begin
            synced_q     <= 1'b1;
            frame_init_q <= 1'b1;
            row0_done_q  <= 1'b0;
            // Aborting a late line at end of frame is harmless once the
            // previous frame got its row 0; anything else is lost data.
            if (fetching && !row0_done_q) begin
               underrun_q <= 1'b1;
            end
         end else if (swap_evt) begin
            disp_q       <= ~disp_q;
            frame_init_q <= 1'b0;
            if (fetching) begin
               underrun_q <= 1'b1;
            end
         end else if (fetch_done && frame_init_q) begin
            row0_done_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Line buffers
   // ---------------------------------------------------------------------------
   // Capture the pixel while mem_data is valid; it is written one cycle later.
   always_ff @(posedge clk27) begin
      if ((state_q == S_REQ) && mem_ack) begin
         data_q <= mem_data;
      end
   end

   // Fill-buffer write port, owned exclusively by the fetch engine.
   always_ff @(posedge clk27) begin
      // NOTE: the line buffers have no reset; they are plain RAM and every
      // displayed word is written by a fetch before it is shown.
      if (buf_we) begin
         line_buf[fill_sel][col_q] <= data_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Pixel path
   // ---------------------------------------------------------------------------
   // On a swap cycle the pixel already comes from the newly displayed buffer.
   assign rd_sel     = swap_evt ? ~disp_q : disp_q;
   assign x_src      = current_x >> 1;
   assign x_in_range = (x_src < 10'(SRC_W));

   // Registered pixel: blanked whenever the previous cycle had request low.
   always_ff @(posedge clk27 or posedge rst27) begin
      if (rst27) begin
         pix_q <= '0;
      end else if (request && x_in_range) begin
         pix_q <= line_buf[rd_sel][x_src[COL_W-1:0]];
      end else begin
         pix_q <= '0;
      end
   end

endmodule

// File: tb/tb_vga_line_fetch.sv
// -----------------------------------------------------------------------------
// tb_vga_line_fetch
// Directed bench for vga_line_fetch: a memory responder with programmable ack
// delay answers reads from an image whose pixel value is (col + 3*row) mod 256.
// -----------------------------------------------------------------------------
module tb_vga_line_fetch;

   logic        clk27;
   logic        rst27;
   logic [9:0]  current_x;
   logic [9:0]  current_y;
   logic        request;
   logic        vga_vs;
   logic        mem_rd;
   logic [16:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;
   logic [9:0]  r, g, b;
   logic        busy;
   logic        underrun;

   int n_tests = 0;
   int n_fail  = 0;

   // responder controls
   int  ack_delay  = 1;
   bit  rand_delay = 1'b0;
   bit  stall      = 1'b0;
   bit  mon_en     = 1'b0;
   int  wait_cnt   = 0;
   int  cur_delay  = 0;

   // read log and protocol monitor
   int          n_reads    = 0;
   logic [16:0] first_addr = '0;
   logic [16:0] last_addr  = '0;
   int          seq_err    = 0;
   int          stab_err   = 0;
   int          outst_err  = 0;
   bit          prev_wait  = 1'b0;
   bit          prev_ack   = 1'b0;
   logic [16:0] prev_addr  = '0;

   vga_line_fetch #(.SRC_W(320), .SRC_H(240)) dut (
      .clk27    (clk27),
      .rst27    (rst27),
      .current_x(current_x),
      .current_y(current_y),
      .request  (request),
      .vga_vs   (vga_vs),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_data (mem_data),
      .r        (r),
      .g        (g),
      .b        (b),
      .busy     (busy),
      .underrun (underrun)
   );

   initial begin
      clk27 = 1'b0;
      forever #5 clk27 = ~clk27;
   end

   function automatic logic [7:0] img(input logic [16:0] a);
      int row, col;
      row = int'(a) / 320;
      col = int'(a) % 320;
      return 8'(col + 3 * row);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk27);
   endtask

   task automatic clear_log();
      n_reads   = 0;
      seq_err   = 0;
      stab_err  = 0;
      outst_err = 0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk27);
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   // Memory model: acks a pending read after cur_delay wait cycles.
   initial begin : responder
      mem_ack  = 1'b0;
      mem_data = '0;
      forever begin
         @(negedge clk27);
         if (mon_en && prev_wait && mem_rd && (mem_addr !== prev_addr)) stab_err++;
         if (mon_en && prev_ack && mem_rd) outst_err++;
         mem_ack = 1'b0;
         if (rst27 || !mem_rd) begin
            wait_cnt  = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 5)) : ack_delay;
         end else if (!stall) begin
            if (wait_cnt >= cur_delay) begin
               mem_ack  = 1'b1;
               mem_data = img(mem_addr);
               if (n_reads == 0) first_addr = mem_addr;
               else if (mem_addr !== last_addr + 17'd1) seq_err++;
               last_addr = mem_addr;
               n_reads++;
               wait_cnt  = 0;
               cur_delay = rand_delay ? int'($urandom_range(0, 5)) : ack_delay;
            end else begin
               wait_cnt++;
            end
         end
         prev_wait = mem_rd && !mem_ack;
         prev_ack  = mem_ack;
         prev_addr = mem_addr;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin : stim
      rst27     = 1'b1;
      vga_vs    = 1'b1;
      request   = 1'b0;
      current_x = '0;
      current_y = '0;

      // ---- reset state
      tick(3);
      check("rst_mem_rd",   32'(mem_rd),   32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_r",        32'(r),        32'd0);
      rst27 = 1'b0;

      // ---- no fetch before the first frame sync
      tick(2);
      request = 1'b1;
      tick(3);
      check("presync_busy", 32'(busy), 32'd0);
      request = 1'b0;
      tick(2);

      // ---- frame-sync fill of row 0, ack one cycle late
      ack_delay = 1;
      clear_log();
      vga_vs = 1'b0;
      tick(1);
      vga_vs = 1'b1;
      check("fs_mem_rd",   32'(mem_rd),   32'd1);
      check("fs_mem_addr", 32'(mem_addr), 32'd0);
      wait_idle("fs_done", 2000);
      check("fs_reads",    32'(n_reads),    32'd320);
      check("fs_first",    32'(first_addr), 32'd0);
      check("fs_last",     32'(last_addr),  32'd319);
      check("fs_seq",      32'(seq_err),    32'd0);
      check("fs_underrun", 32'(underrun),   32'd0);

      // ---- swap at y=0 shows row 0, fetches row 1
      clear_log();
      current_y = 10'd0;
      current_x = 10'd0;
      request   = 1'b1;
      tick(1);
      check("sw0_busy", 32'(busy),     32'd1);
      check("sw0_addr", 32'(mem_addr), 32'd320);
      current_x = 10'd7;
      tick(1);
      check("pix7_r", 32'(r), 32'd12);
      check("pix7_g", 32'(g), 32'd12);
      check("pix7_b", 32'(b), 32'd12);
      current_x = 10'd400;
      tick(1);
      check("pix400_r", 32'(r), 32'd803);
      request = 1'b0;
      tick(1);
      check("blank_r", 32'(r), 32'd0);
      wait_idle("row1_done", 2000);
      check("row1_first", 32'(first_addr), 32'd320);
      check("row1_last",  32'(last_addr),  32'd639);

      // ---- swap at y=2: display row 1, fetch row 2 at 640
      clear_log();
      current_y = 10'd2;
      current_x = 10'd7;
      request   = 1'b1;
      tick(1);
      check("sw2_addr", 32'(mem_addr), 32'd640);
      check("sw2_r",    32'(r),        32'd24);
      wait_idle("row2_done", 2000);
      check("row2_first", 32'(first_addr), 32'd640);

      // ---- rising edge on an odd row: nothing happens
      request = 1'b0;
      tick(1);
      current_y = 10'd1;
      request   = 1'b1;
      tick(3);
      check("odd_busy",   32'(busy),   32'd0);
      check("odd_mem_rd", 32'(mem_rd), 32'd0);

      // ---- swap at y=478: row 240 is past the image, stay idle
      request = 1'b0;
      tick(1);
      current_y = 10'd478;
      request   = 1'b1;
      tick(1);
      check("sw478_r", 32'(r), 32'd36);
      tick(2);
      check("sw478_busy",     32'(busy),     32'd0);
      check("sw478_underrun", 32'(underrun), 32'd0);

      // ---- underrun: stall row 3, swap at y=6 restarts with row 4
      request = 1'b0;
      stall   = 1'b1;
      tick(1);
      current_y = 10'd4;
      request   = 1'b1;
      tick(1);
      check("ur_addr3", 32'(mem_addr), 32'd960);
      tick(5);
      check("ur_hold",  32'(mem_addr), 32'd960);
      check("ur_pre",   32'(underrun), 32'd0);
      request = 1'b0;
      tick(1);
      current_y = 10'd6;
      request   = 1'b1;
      tick(1);
      check("ur_flag",  32'(underrun), 32'd1);
      check("ur_addr4", 32'(mem_addr), 32'd1280);
      check("ur_rd",    32'(mem_rd),   32'd1);
      clear_log();
      stall   = 1'b0;
      request = 1'b0;
      wait_idle("row4_done", 2000);
      check("row4_first", 32'(first_addr), 32'd1280);
      check("ur_sticky",  32'(underrun),   32'd1);

      // ---- random ack delay handshake
      clear_log();
      rand_delay = 1'b1;
      mon_en     = 1'b1;
      vga_vs     = 1'b0;
      tick(1);
      vga_vs = 1'b1;
      wait_idle("rnd_done", 4000);
      mon_en     = 1'b0;
      rand_delay = 1'b0;
      check("rnd_reads",  32'(n_reads),   32'd320);
      check("rnd_last",   32'(last_addr), 32'd319);
      check("rnd_seq",    32'(seq_err),   32'd0);
      check("rnd_stable", 32'(stab_err),  32'd0);
      check("rnd_single", 32'(outst_err), 32'd0);
      check("rnd_sticky", 32'(underrun),  32'd1);

      // ---- asynchronous reset in the middle of a fetch
      ack_delay = 3;
      current_y = 10'd1;
      current_x = 10'd7;
      request   = 1'b1;
      vga_vs    = 1'b0;
      tick(1);
      vga_vs = 1'b1;
      tick(5);
      check("ar_busy_pre", 32'(busy), 32'd1);
      check("ar_r_pre",    32'(r),    32'd36);
      @(posedge clk27);
      #3;
      rst27 = 1'b1;
      #1;
      check("ar_mem_rd",   32'(mem_rd),   32'd0);
      check("ar_busy",     32'(busy),     32'd0);
      check("ar_r",        32'(r),        32'd0);
      check("ar_g",        32'(g),        32'd0);
      check("ar_b",        32'(b),        32'd0);
      check("ar_underrun", 32'(underrun), 32'd0);
      tick(1);
      request = 1'b0;
      tick(1);
      rst27 = 1'b0;
      tick(1);
      current_y = 10'd0;
      request   = 1'b1;
      tick(3);
      check("ar_nofetch", 32'(busy), 32'd0);
      request = 1'b0;
      vga_vs  = 1'b0;
      tick(1);
      vga_vs = 1'b1;
      check("ar_refetch_busy", 32'(busy),     32'd1);
      check("ar_refetch_addr", 32'(mem_addr), 32'd0);
      wait_idle("ar_refetch_done", 3000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SRC_W, 320: source image width in pixels.
REQ-002 SRC_H, 240: source image height in lines.
REQ-003 clk27  input  1: pixel clock; single clock domain for the whole block.
REQ-004 rst27  input  1: reset, asynchronous and active-high.
REQ-005 current_x  input  10: display column, 0..639, from the display controller.
REQ-006 current_y  input  10: display row, 0..479, from the display controller.
REQ-007 request  input  1: high while the display controller is in its active pixel area.
REQ-008 vga_vs  input  1: vertical sync, active-low.
REQ-009 mem_rd  output  1: read request to image memory.
REQ-010 mem_addr  output  17: image memory word address.
REQ-011 mem_ack  input  1: read complete; mem_data is valid in the same cycle.
REQ-012 mem_data  input  8: grayscale pixel.
REQ-013 r, g, b  output  10 each: pixel value to the display controller.
REQ-014 busy  output  1: a line fetch is in progress.
REQ-015 underrun  output  1: sticky error flag, set when a fetch was still incomplete at a buffer swap.

Function
REQ-016 The block SHALL hold two line buffers (ping-pong), each SRC_W x 8 bits.
- The display buffer is read-only to the pixel path.
- The fill buffer is written only by the fetch engine.
REQ-017 Upscale: the block SHALL display source pixel (current_x>>1) of the display buffer, so each source line is shown on two display rows.
REQ-018 Output value: r, g and b SHALL each equal {pix, pix[7:6]}.
- Outputs are registered with 1-cycle latency from current_x/request.
- Outputs are 0 in any cycle following a cycle where request was low.
REQ-019 The fetch FSM SHALL have three states:
- IDLE: no fetch in progress.
- REQ: mem_rd is high.
- WRITE: store pixel, advance column.
REQ-020 Fetch start: IDLE -> REQ, with column 0 and source row R.
REQ-021 REQ: mem_rd=1 and mem_addr=R*SRC_W+col SHALL be held stable until mem_ack; on mem_ack, go to WRITE.
REQ-022 WRITE: store mem_data in fill[col], then:
- if col==SRC_W-1, go to IDLE;
- otherwise col+1 and go to REQ.
REQ-023 mem_rd SHALL be low in IDLE and WRITE, so at most one read is outstanding at a time.
REQ-024 Frame sync: on the falling edge of vga_vs (registered edge detect), the block SHALL:
- abort any fetch;
- mark the next swap as frame-initial;
- start fetching source row 0 into the fill buffer.
REQ-025 Line swap: on a rising edge of request with current_y[0]==0, the block SHALL exchange the display and fill buffers.
- It SHALL then start fetching source row (current_y>>1)+1 if that row is < SRC_H; otherwise it remains IDLE.
REQ-026 If the FSM is not IDLE at a swap or at frame sync, the block SHALL set underrun=1 and restart the fetch from column 0 with the new row.
- The abort is silent and does not set underrun when it comes from frame sync after row 0 of the previous frame completed.
REQ-027 If a swap and a frame-sync edge occur in the same cycle, frame sync SHALL take priority.
REQ-028 A rising edge of request with current_y[0]==1 SHALL cause no swap and no fetch.
REQ-029 busy SHALL equal (state != IDLE).
REQ-030 Address arithmetic SHALL be unsigned at 17 bits; the maximum address is 76799.

Reset
REQ-031 While rst27 is high, the block SHALL force:
- state=IDLE;
- mem_rd=0, mem_addr=0;
- r=g=b=0;
- busy=0, underrun=0;
- display buffer index 0, column 0;
- edge detectors as if vga_vs=1 and request=0.
REQ-032 Line-buffer contents are not reset.
REQ-033 A reset mid-fetch SHALL drop mem_rd in the same cycle and discard the partial line.
REQ-034 After release, the first fetch SHALL wait for a vga_vs falling edge.

Verification
REQ-035 Frame-sync fill: vga_vs 1->0, memory acks each request 1 cycle late -> 320 reads at addresses 0..319; busy falls after the last WRITE; underrun=0.
REQ-036 Pixel path: memory row 0 = col value; swap at current_y=0; then current_x=7 with request=1 -> next cycle r=g=b={8'd3, 2'b00}; request=0 -> 0 the following cycle.
REQ-037 Row progression: rising edge of request at current_y=2 -> fetch addresses start at 640; rising edge at current_y=1 -> no fetch; rising edge at current_y=478 -> row 240 is not fetched and the FSM stays IDLE.
REQ-038 Underrun: mem_ack stalled until the next even-row swap -> underrun=1 and stays 1; mem_addr restarts at (new row)*320.
REQ-039 Handshake stability: random mem_ack delay 0..5 cycles -> mem_addr constant while mem_rd=1 and no ack; never more than one outstanding read.
REQ-040 Async reset asserted mid-fetch between clock edges -> mem_rd=0, busy=0 and r=g=b=0 immediately; no fetch until the next vga_vs falling edge.
